sram_rmw_ctrl: RTL
==================

# sram_rmw_ctrl

Byte-wide access controller between the SoC's 8-bit CPU bus and the 16-bit asynchronous external SRAM (18-bit word address, shared OE/WE/CS, no byte enables). It maps a 19-bit byte address onto word address plus byte lane. Reads return the selected byte. Byte writes are done as read-modify-write, so the other byte of the word is preserved. It sits directly downstream of the SoC bus decode and drives the SRAM pad cells.

## Interface
Parameters:
- WAIT_STATES, 1: cycles OE or WE is held low per SRAM access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  19  byte address; addr[18:1] is the SRAM word, addr[0] is the lane (0 = [7:0], 1 = [15:8]).
- wdata  in  8  write byte.
- rd  in  1  read request, level.
- wr  in  1  write request, level.
- rdata  out  8  last read byte; held until the next read completes.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at completion of each access.
- sram_addr  out  18  SRAM word address.
- sram_dq_in  in  16  data from pads.
- sram_dq_out  out  16  data to pads.
- sram_dq_oe  out  1  pad output enable.
- sram_oe_n, sram_we_n, sram_cs_n  out  1 each  active-low SRAM strobes.

## Operation
- One clock domain. Reset is asynchronous and active-low.
- All outputs are registered; strobes never glitch.
- Reset values:
  - FSM = IDLE.
  - sram_cs_n = sram_oe_n = sram_we_n = 1.
  - sram_dq_oe = 0, busy = 0, done = 0.
  - rdata = 0, sram_addr = 0, sram_dq_out = 0.
- IDLE: on a rising edge with rd or wr high, latch addr, wdata and the operation type, then go to READ.
  - wr takes priority if rd and wr are both high.
  - rd/wr are ignored outside IDLE. A requester waits for done, then drops or re-presents its request.
- READ: cs_n = 0, oe_n = 0, we_n = 1, dq_oe = 0, sram_addr = latched addr[18:1].
  - A down-counter (WAIT_STATES-1 .. 0) runs here.
  - On the edge leaving the state, sram_dq_in is captured into the 16-bit word register.
  - A read request goes to HOLD; a write request goes to WSETUP.
- WSETUP (1 cycle): bus turnaround.
  - cs_n = 0, oe_n = 1, we_n = 1, dq_oe = 1.
  - sram_dq_out = captured word with the lane selected by addr[0] replaced by wdata; the other byte is unchanged.
- WRITE: cs_n = 0, we_n = 0, dq_oe = 1, data and address stable; lasts WAIT_STATES cycles.
- HOLD (1 cycle): cs_n = 1, oe_n = 1, we_n = 1, done = 1, then IDLE.
  - On a write, dq_oe stays 1 in HOLD for data hold time and drops to 0 on the return to IDLE.
  - On a read, rdata is updated on entry to HOLD with the selected byte of the captured word, so it is valid in the done cycle.
- Reset mid-access: all strobes deassert and dq_oe drops immediately (asynchronously), the FSM returns to IDLE, and no done pulse is generated. A partially written word is acceptable.

## Timing
- Cycle numbering: the edge that accepts a request starts cycle 0.
- Read:
  - READ occupies cycles 0..W-1; HOLD is cycle W.
  - done and valid rdata appear in cycle W.
  - busy is high for W+1 cycles.
- Write:
  - READ occupies cycles 0..W-1, WSETUP is cycle W, WRITE is cycles W+1..2W, HOLD is cycle 2W+1.
  - done is in cycle 2W+1; busy is high for 2W+2 cycles.
- Back-to-back: a request held high through done is re-accepted on the edge ending HOLD's successor IDLE cycle. There is a minimum of one IDLE cycle (cs_n = 1) between accesses, which is the SRAM recovery time.
- sram_addr changes only on entry to READ. It is stable through READ, WSETUP, WRITE and HOLD.
- Counter width is 4 bits. W = 1 gives single-cycle READ and WRITE states with no extra states.

## Test plan
- W=1, SRAM model word 0x0123 = 0xBEEF, read byte addr 0x00246 (lane 0) -> done in cycle 1, rdata = 0xEF, oe_n low exactly 1 cycle. Then read addr 0x00247 (lane 1) -> rdata = 0xBE.
- W=3, word 0x3FFFF = 0x1234, write 0xAA to byte addr 0x7FFFF (lane 1) -> word becomes 0xAA34, we_n low exactly cycles 4..6, done in cycle 7, busy 8 cycles, dq_oe never high while oe_n low.
- rd and wr both high with wdata 0x55 at lane 0 of word 0x10 = 0xFFFF -> write performed, word = 0xFF55, rdata unchanged.
- rd held continuously with W=2 -> successive done pulses 4 cycles apart; cs_n high for at least one cycle between accesses; requests during busy produce no extra access.
- Assert reset_n low during the WRITE of a W=3 byte write -> cs_n, we_n and oe_n go to 1 and dq_oe to 0 without waiting for a clock edge; no done pulse; after release, busy = 0 and a fresh read completes normally.

Source files
------------

// File: rtl/sram_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// sram_rmw_ctrl
//
// Byte-wide access controller between the 8-bit CPU bus and a 16-bit
// asynchronous external SRAM with no byte enables. A 19-bit byte address is
// split into an 18-bit word address (addr[18:1]) and a byte lane (addr[0]).
// Reads return the selected byte. Byte writes are performed as a
// read-modify-write, so the other byte of the word is preserved.
//
// Parameters:
//   WAIT_STATES  cycles OE or WE is held low per SRAM access (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   addr         byte address (word = addr[18:1], lane = addr[0])
//   wdata        byte to write
//   rd, wr       level-sensitive read / write requests (wr has priority)
//   rdata        last byte read, held until the next read completes
//   busy         high whenever an access is in progress
//   done         one-cycle pulse in the final cycle of each access
//   sram_addr    SRAM word address
//   sram_dq_in   data from the pads
//   sram_dq_out  data to the pads
//   sram_dq_oe   pad output enable
//   sram_oe_n    SRAM output enable strobe, active low
//   sram_we_n    SRAM write enable strobe, active low
//   sram_cs_n    SRAM chip select strobe, active low
// ---------------------------------------------------------------------------
module sram_rmw_ctrl #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [18:0] addr,
    input  logic [7:0]  wdata,
    input  logic        rd,
    input  logic        wr,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_cs_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WSETUP = 3'd2,
        WRITE  = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Reload value of the 4-bit wait-state down-counter; a value of 0 makes
    // READ and WRITE last a single cycle each.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        op_write;
    logic        lane;
    logic [7:0]  wbyte;

    // Single state machine. Every output, including the SRAM strobes, is a
    // flop so the pads never see a glitch. The strobes and the pad enable
    // sit on the asynchronous reset, so a reset in the middle of an access
    // releases the SRAM bus at once rather than on the next edge.
    //
    // The word read in READ is merged with the write byte on the same edge
    // that leaves READ, so the merged word lands directly in sram_dq_out and
    // no separate copy of the old word has to be kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            op_write    <= 1'b0;
            lane        <= 1'b0;
            wbyte       <= 8'd0;
            rdata       <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_cs_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Both read and write start with a read of the word;
                    // a write request wins when rd and wr arrive together.
                    if (rd || wr) begin
                        op_write  <= wr;
                        lane      <= addr[0];
                        wbyte     <= wdata;
                        sram_addr <= addr[18:1];
                        wait_cnt  <= CNT_INIT;
                        busy      <= 1'b1;
                        sram_cs_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_we_n <= 1'b1;
                        state     <= READ;
                    end
                end

                READ: begin
                    if (wait_cnt == 4'd0) begin
                        sram_oe_n <= 1'b1;
                        if (op_write) begin
                            // Turnaround cycle: OE is released and the pads
                            // start driving the merged word on the same edge.
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= lane ? {wbyte, sram_dq_in[7:0]}
                                                : {sram_dq_in[15:8], wbyte};
                            state       <= WSETUP;
                        end else begin
                            rdata     <= lane ? sram_dq_in[15:8] : sram_dq_in[7:0];
                            sram_cs_n <= 1'b1;
                            done      <= 1'b1;
                            state     <= HOLD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WSETUP: begin
                    sram_we_n <= 1'b0;
                    wait_cnt  <= CNT_INIT;
                    state     <= WRITE;
                end

                WRITE: begin
                    if (wait_cnt == 4'd0) begin
                        // WE and CS rise together; the pads keep driving
                        // through HOLD to cover the SRAM data hold time.
                        sram_we_n <= 1'b1;
                        sram_cs_n <= 1'b1;
                        done      <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                HOLD: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    sram_dq_oe <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
